// File: rtl/pio_bank_pkg.sv
// Shared address map, edge-mode encoding and byte-lane helper for the Avalon-MM PIO bank.
package pio_bank_pkg;

  localparam int OUT_BASE  = 0;
  localparam int IN_BASE   = 16;
  localparam int IN_STRIDE = 4;

  localparam int OFF_DATA = 0;
  localparam int OFF_MASK = 1;
  localparam int OFF_EDGE = 2;
  localparam int OFF_MODE = 3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  // Expands the four Avalon byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/pio_in_channel.sv
// One input channel: synchroniser, optional debouncer (PIO_BANK_DEBOUNCE_EN), prime flag,
// edge capture and the channel's MASK / EDGE / MODE registers.
module pio_in_channel
  import pio_bank_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 62500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pin,
  input  logic              mask_we,
  input  logic              edge_w1c,
  input  logic              mode_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic [1:0]        mode_wdata,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] edge_flags,
  output logic [1:0]        mode,
  output logic              irq_req
);

  logic [DATA_W-1:0] sync1_q, sync2_q, prev_q, mask_q, edge_q;
  logic [DATA_W-1:0] clean, rise, fall, hit, clr;
  logic [1:0]        fill_q;
  logic              primed_q, prime_now;
  edge_mode_e        mode_q;

  // The prime sample waits until the synchroniser holds a real pin value, not its reset zeros.
  assign prime_now = fill_q[1] & ~primed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      sync1_q  <= pin;
      sync2_q  <= sync1_q;
      fill_q   <= {fill_q[0], 1'b1};
      primed_q <= primed_q | fill_q[1];
    end
  end

`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DATA_W-1:0] clean_q;
  logic [CNT_W-1:0]  cnt_q [DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean_q <= '0;
      for (int i = 0; i < DATA_W; i++) cnt_q[i] <= '0;
    end else if (prime_now) begin
      clean_q <= sync2_q;
      for (int i = 0; i < DATA_W; i++) cnt_q[i] <= '0;
    end else if (primed_q) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (sync2_q[i] == clean_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          clean_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign clean = clean_q;
  assign data  = clean_q;
`else
  assign clean = sync2_q;
  assign data  = prev_q;
`endif

  assign rise = clean & ~prev_q;
  assign fall = ~clean & prev_q;

  always_comb begin
    hit = '0;
    if (primed_q) begin
      case (mode_q)
        EDGE_RISE: hit = rise;
        EDGE_FALL: hit = fall;
        EDGE_BOTH: hit = rise | fall;
        default:   hit = '0;
      endcase
    end
  end

  assign clr = edge_w1c ? (wdata & wmask) : '0;

  // A new edge is OR-ed in after the clear, so it wins over a simultaneous W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      mode_q <= EDGE_RISE;
    end else begin
      if (prime_now) begin
        prev_q <= sync2_q;
      end else if (primed_q) begin
        prev_q <= clean;
      end
      edge_q <= (edge_q & ~clr) | hit;
      if (mask_we) mask_q <= (mask_q & ~wmask) | (wdata & wmask);
      if (mode_we) mode_q <= edge_mode_e'(mode_wdata);
    end
  end

  assign mask       = mask_q;
  assign edge_flags = edge_q;
  assign mode       = mode_q;
  assign irq_req    = |(edge_q & mask_q);

endmodule

// File: rtl/avmm_pio_bank.sv
// Avalon-MM PIO bank top: address decode, output registers, readback mux and registered irq.
// Input debouncing is enabled by defining PIO_BANK_DEBOUNCE_EN.
module avmm_pio_bank
  import pio_bank_pkg::*;
#(
  parameter int          NUM_OUT         = 6,
  parameter int          NUM_IN          = 2,
  parameter int          DATA_W          = 32,
  parameter int          ADDR_W          = 6,
  parameter logic [31:0] OUT_RESET_VAL   = 32'h0,
  parameter int          DEBOUNCE_CYCLES = 62500
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  input  logic [3:0]                avs_byteenable,
  output logic [31:0]               avs_readdata,
  output logic                      irq,
  output logic [NUM_OUT*DATA_W-1:0] pio_out,
  input  logic [NUM_IN*DATA_W-1:0]  pio_in
);

  localparam logic [31:0] RST_WORD = OUT_RESET_VAL;

  logic [31:0]       be_mask;
  logic [DATA_W-1:0] wmask, wdata;
  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [31:0]       rd_mux;

  logic [NUM_IN-1:0][DATA_W-1:0] ch_data, ch_mask, ch_edge;
  logic [NUM_IN-1:0][1:0]        ch_mode;
  logic [NUM_IN-1:0]             ch_irq;

  assign be_mask = lane_mask(avs_byteenable);
  assign wmask   = be_mask[DATA_W-1:0];
  assign wdata   = avs_writedata[DATA_W-1:0];

  genvar c;
  generate
    for (c = 0; c < NUM_IN; c++) begin : g_in
      localparam int BASE = IN_BASE + IN_STRIDE * c;

      pio_in_channel #(
        .DATA_W         (DATA_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .pin       (pio_in[c*DATA_W +: DATA_W]),
        .mask_we   (avs_write && (avs_address == ADDR_W'(BASE + OFF_MASK))),
        .edge_w1c  (avs_write && (avs_address == ADDR_W'(BASE + OFF_EDGE))),
        .mode_we   (avs_write && avs_byteenable[0] && (avs_address == ADDR_W'(BASE + OFF_MODE))),
        .wdata     (wdata),
        .wmask     (wmask),
        .mode_wdata(avs_writedata[1:0]),
        .data      (ch_data[c]),
        .mask      (ch_mask[c]),
        .edge_flags(ch_edge[c]),
        .mode      (ch_mode[c]),
        .irq_req   (ch_irq[c])
      );
    end

    for (c = 0; c < NUM_OUT; c++) begin : g_out
      assign pio_out[c*DATA_W +: DATA_W] = out_q[c];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= RST_WORD[DATA_W-1:0];
    end else if (avs_write) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (avs_address == ADDR_W'(OUT_BASE + k)) begin
          out_q[k] <= (out_q[k] & ~wmask) | (wdata & wmask);
        end
      end
    end
  end

  // Anything not matched below, including absent channels, reads back as zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (avs_address == ADDR_W'(OUT_BASE + k)) rd_mux = 32'(out_q[k]);
    end
    for (int n = 0; n < NUM_IN; n++) begin
      if (avs_address == ADDR_W'(IN_BASE + IN_STRIDE * n + OFF_DATA)) rd_mux = 32'(ch_data[n]);
      if (avs_address == ADDR_W'(IN_BASE + IN_STRIDE * n + OFF_MASK)) rd_mux = 32'(ch_mask[n]);
      if (avs_address == ADDR_W'(IN_BASE + IN_STRIDE * n + OFF_EDGE)) rd_mux = 32'(ch_edge[n]);
      if (avs_address == ADDR_W'(IN_BASE + IN_STRIDE * n + OFF_MODE)) rd_mux = 32'(ch_mode[n]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      irq <= |ch_irq;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avmm_pio_bank.sv
// Scoreboard bench for avmm_pio_bank: reads push expected data, a monitor checks each response.
module tb_avmm_pio_bank;

  localparam logic [31:0] RV     = 32'hA5A5_3C3C;
  localparam int          SETTLE = 20;
`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int EDGE_LAT = 11;
`else
  localparam int EDGE_LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   avs_address = '0;
  logic         avs_read = 1'b0;
  logic         avs_write = 1'b0;
  logic [31:0]  avs_writedata = '0;
  logic [3:0]   avs_byteenable = '0;
  logic [31:0]  avs_readdata;
  logic         irq;
  logic [191:0] pio_out;
  logic [63:0]  pio_in = '1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  always #5 clk = ~clk;

  avmm_pio_bank #(
    .NUM_OUT        (6),
    .NUM_IN         (2),
    .DATA_W         (32),
    .ADDR_W         (6),
    .OUT_RESET_VAL  (RV),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_byteenable(avs_byteenable),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pio_out       (pio_out),
    .pio_in        (pio_in)
  );

  task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Write one word; starts and ends on a falling edge.
  task automatic applyStimulus(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    @(negedge clk);
    avs_write      = 1'b0;
    avs_byteenable = '0;
  endtask

  task automatic readExpect(input logic [5:0] a, input logic [31:0] expected, input string name);
    exp_q.push_back(expected);
    name_q.push_back(name);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) rd_seen <= avs_read && !reset;

  // Read responses are valid on the cycle after avs_read was sampled.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_read: got %h, expected no response", avs_readdata);
      end else begin
        logic [31:0] mon_exp;
        string       mon_name;
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checkOutput(mon_name, {160'd0, avs_readdata}, {160'd0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with all inputs high: prime must suppress spurious edges.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(10);
    checkOutput("irq_after_reset", {191'd0, irq}, 192'd0);
    checkOutput("pio_out_reset", pio_out, {6{RV}});
    checkOutput("readdata_reset", {160'd0, avs_readdata}, 192'd0);
    readExpect(6'd18, 32'h0, "edge0_after_reset");
    readExpect(6'd22, 32'h0, "edge1_after_reset");
    readExpect(6'd16, 32'hFFFF_FFFF, "data0_high");
    readExpect(6'd0, RV, "out0_reset");

    // Byte-enabled write to OUT[2].
    applyStimulus(6'd2, 32'h0, 4'hF);
    applyStimulus(6'd2, 32'hDEAD_BEEF, 4'b0011);
    checkOutput("pio_out_ch2_be", {160'd0, pio_out[64 +: 32]}, {160'd0, 32'h0000_BEEF});
    checkOutput("pio_out_ch3_untouched", {160'd0, pio_out[96 +: 32]}, {160'd0, RV});
    readExpect(6'd2, 32'h0000_BEEF, "out2_read");

    // Falling edges ignored in rise mode, then a rising edge on ch0 bit0.
    pio_in = '0;
    idle(SETTLE);
    readExpect(6'd18, 32'h0, "edge0_fall_ignored");
    applyStimulus(6'd19, 32'h0, 4'hF);
    applyStimulus(6'd17, 32'h1, 4'hF);
    readExpect(6'd19, 32'h0, "mode0_rise");
    pio_in[0] = 1'b1;
    idle(EDGE_LAT - 1);
    readExpect(6'd18, 32'h0, "edge0_before_latency");
    checkOutput("irq_before_edge", {191'd0, irq}, 192'd0);
    readExpect(6'd18, 32'h1, "edge0_set");
    checkOutput("irq_set", {191'd0, irq}, 192'd1);
    readExpect(6'd16, 32'h1, "data0_bit0");
    applyStimulus(6'd18, 32'h1, 4'b0001);
    idle(1);
    checkOutput("irq_cleared_w1c", {191'd0, irq}, 192'd0);

    // Both-edge mode; W1C coinciding with a new edge keeps the bit set.
    applyStimulus(6'd19, 32'h2, 4'b0001);
    pio_in[0] = 1'b0;
    idle(EDGE_LAT + 2);
    checkOutput("irq_fall_both", {191'd0, irq}, 192'd1);
    applyStimulus(6'd18, 32'h1, 4'b1110);
    idle(1);
    checkOutput("irq_w1c_lane_off", {191'd0, irq}, 192'd1);
    pio_in[0] = 1'b1;
    idle(EDGE_LAT - 1);
    applyStimulus(6'd18, 32'h1, 4'b0001);
    idle(1);
    checkOutput("irq_edge_wins", {191'd0, irq}, 192'd1);
    readExpect(6'd18, 32'h1, "edge0_edge_wins");
    applyStimulus(6'd18, 32'h1, 4'b0001);
    idle(1);
    checkOutput("irq_final_clear", {191'd0, irq}, 192'd0);

`ifdef PIO_BANK_DEBOUNCE_EN
    // Short glitch is rejected; a long level lands 10 cycles after the pin moves.
    pio_in[1] = 1'b1;
    idle(5);
    pio_in[1] = 1'b0;
    idle(SETTLE);
    readExpect(6'd16, 32'h1, "data0_glitch_rejected");
    readExpect(6'd18, 32'h0, "edge0_glitch_none");
    pio_in[1] = 1'b1;
    idle(9);
    readExpect(6'd16, 32'h1, "data0_pre_debounce");
    readExpect(6'd16, 32'h3, "data0_debounced");
`endif

    readExpect(6'd40, 32'h0, "unmapped_read");

    // Raise irq from ch1, then reset asynchronously in the middle of a read/write burst.
    applyStimulus(6'd21, 32'h1, 4'hF);
    pio_in[32] = 1'b1;
    idle(EDGE_LAT + 2);
    checkOutput("irq_ch1", {191'd0, irq}, 192'd1);
    readExpect(6'd2, 32'h0000_BEEF, "out2_before_reset");
    exp_q.push_back(RV);
    name_q.push_back("burst_read");
    avs_address    = 6'd3;
    avs_writedata  = 32'h1234_5678;
    avs_byteenable = 4'hF;
    avs_write      = 1'b1;
    avs_read       = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("readdata_async_reset", {160'd0, avs_readdata}, 192'd0);
    checkOutput("irq_async_reset", {191'd0, irq}, 192'd0);
    checkOutput("pio_out_async_reset", pio_out, {6{RV}});
    avs_write      = 1'b0;
    avs_read       = 1'b0;
    avs_byteenable = '0;
    idle(2);
    reset = 1'b0;
    idle(SETTLE);
    checkOutput("irq_after_rereset", {191'd0, irq}, 192'd0);
    readExpect(6'd22, 32'h0, "edge1_primed_no_spurious");
    readExpect(6'd21, 32'h0, "mask1_reset");

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL read_drain: got %0d pending responses, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
